fighter_fsm: RTL and testbench

Parametrised per-player fighter controller, successor to the fixed-timing player block. It advances one game frame per `tick` strobe and owns the fighter's action state, horizontal position, health and KO status. Every frame duration, speed and damage value is a parameter. It sits between the input debouncer / hit-detection logic and the renderer, one instance per side.

---
 rtl/fighter_pkg.sv | 49 ++++
 rtl/fighter_fsm_frame_counter.sv | 33 +++
 rtl/fighter_fsm.sv | 155 +++++++++++++++
 tb/tb_fighter_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Shared codes and helpers for the per-player fighter controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FWD   = 4'd1,
    ST_BACK  = 4'd2,
    ST_B_ST  = 4'd3,
    ST_B_ACT = 4'd4,
    ST_B_REC = 4'd5,
    ST_D_ST  = 4'd6,
    ST_D_ACT = 4'd7,
    ST_D_REC = 4'd8,
    ST_HSTUN = 4'd9,
    ST_BSTUN = 4'd10,
    ST_KO    = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    HIT_NONE = 2'b00,
    HIT_B    = 2'b01,
    HIT_D    = 2'b10,
    HIT_BAD  = 2'b11
  } hit_e;

  localparam logic [1:0] ATK_NONE = 2'b00;
  localparam logic [1:0] ATK_B    = 2'b01;
  localparam logic [1:0] ATK_D    = 2'b10;

  localparam logic [9:0] POSY  = 10'd170;
  localparam int         CNT_W = 8;

  // True on the last tick of a phase lasting n ticks (count started at 0).
  function automatic logic is_last(input logic [CNT_W-1:0] c, input int n);
    return c == CNT_W'(n - 1);
  endfunction

  // Hitbox code presented to the renderer / hit detection for a state.
  function automatic logic [1:0] atk_code(input state_e s);
    case (s)
      ST_B_ACT: return ATK_B;
      ST_D_ACT: return ATK_D;
      default:  return ATK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fighter_fsm_frame_counter.sv
// Counts ticks spent in the current fighter state; saturates at all-ones.
// Latency: count visible one clock after the qualifying tick.
// Backpressure: none; holds whenever en_i is low.
module frame_counter
  import fighter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Clear on state change, otherwise count up (saturating) on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fighter_fsm.sv
// Per-player fighter controller: action state, position, health and KO.
// Latency: all outputs registered, updated on the clock edge of a tick cycle.
// Backpressure: none; state holds on non-tick cycles, inputs sampled only on tick.
module fighter_fsm
  import fighter_pkg::*;
#(
  parameter int SIDE      = 0,
  parameter int X_INIT    = 100,
  parameter int X_MIN     = 10,
  parameter int X_MAX     = 517,
  parameter int SPD_FWD   = 3,
  parameter int SPD_BACK  = 2,
  parameter int B_START   = 5,
  parameter int B_ACTIVE  = 2,
  parameter int B_RECOVER = 16,
  parameter int D_START   = 4,
  parameter int D_ACTIVE  = 3,
  parameter int D_RECOVER = 15,
  parameter int HSTUN_B   = 15,
  parameter int HSTUN_D   = 14,
  parameter int BSTUN_B   = 13,
  parameter int BSTUN_D   = 12,
  parameter int DMG_B     = 10,
  parameter int DMG_D     = 15,
  parameter int HP_MAX    = 100,
  parameter int HP_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            left,
  input  logic            right,
  input  logic            attack,
  input  logic [1:0]      hit_flag,
  output logic [9:0]      posx,
  output logic [9:0]      posy,
  output logic [3:0]      state,
  output logic [HP_W-1:0] health,
  output logic [1:0]      atk_active,
  output logic            ko
);

  state_e            state_q, state_d;
  logic [9:0]        posx_q, posx_d;
  logic [HP_W-1:0]   health_q, health_d;
  logic [CNT_W-1:0]  stun_q, stun_d;
  logic [1:0]        atk_q;
  logic              ko_q;
  logic [CNT_W-1:0]  cnt;

  logic              toward, away, hit_b, hit_d;
  state_e            dir_st, resume_st;
  logic [HP_W-1:0]   dmg, hp_after;
  logic [10:0]       spd, sum, lo_lim;
  logic              go_plus;

  frame_counter #(.W(CNT_W)) u_frame_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (tick),
    .clr_i (state_d != state_q),
    .cnt_o (cnt)
  );

  // Decode held inputs into a movement state and the post-phase resume state.
  always_comb begin
    toward    = (SIDE != 0) ? left  : right;
    away      = (SIDE != 0) ? right : left;
    dir_st    = ST_IDLE;
    if (left && right)  dir_st = ST_BACK;
    else if (toward)    dir_st = ST_FWD;
    else if (away)      dir_st = ST_BACK;
    resume_st = attack ? ST_B_ST : dir_st;
    hit_b     = (hit_flag == HIT_B);
    hit_d     = (hit_flag == HIT_D);
    dmg       = hit_d ? HP_W'(DMG_D) : HP_W'(DMG_B);
    hp_after  = (health_q > dmg) ? (health_q - dmg) : '0;
  end

  // Next-state: phase sequencing first, then hits override everything.
  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    stun_d   = stun_q;
    case (state_q)
      ST_IDLE:          state_d = attack ? ST_B_ST : dir_st;
      ST_FWD, ST_BACK:  state_d = attack ? ST_D_ST : dir_st;
      ST_B_ST:          if (is_last(cnt, B_START))   state_d = ST_B_ACT;
      ST_B_ACT:         if (is_last(cnt, B_ACTIVE))  state_d = ST_B_REC;
      ST_B_REC:         if (is_last(cnt, B_RECOVER)) state_d = resume_st;
      ST_D_ST:          if (is_last(cnt, D_START))   state_d = ST_D_ACT;
      ST_D_ACT:         if (is_last(cnt, D_ACTIVE))  state_d = ST_D_REC;
      ST_D_REC:         if (is_last(cnt, D_RECOVER)) state_d = resume_st;
      ST_HSTUN,
      ST_BSTUN:         if (cnt == stun_q - 1'b1)    state_d = resume_st;
      ST_KO:            state_d = ST_KO;
      default:          state_d = ST_IDLE;
    endcase
    if (hit_b || hit_d) begin
      case (state_q)
        ST_BACK: begin
          state_d = ST_BSTUN;
          stun_d  = hit_d ? CNT_W'(BSTUN_D) : CNT_W'(BSTUN_B);
        end
        ST_IDLE, ST_FWD, ST_B_ST, ST_B_ACT, ST_B_REC,
        ST_D_ST, ST_D_ACT, ST_D_REC: begin
          health_d = hp_after;
          stun_d   = hit_d ? CNT_W'(HSTUN_D) : CNT_W'(HSTUN_B);
          state_d  = (hp_after == '0) ? ST_KO : ST_HSTUN;
        end
        default: ;
      endcase
    end
  end

  // Clamped position step driven by the state held before this tick.
  always_comb begin
    go_plus = (state_q == ST_FWD) ? (SIDE == 0) : (SIDE != 0);
    spd     = (state_q == ST_FWD) ? 11'(SPD_FWD) : 11'(SPD_BACK);
    sum     = {1'b0, posx_q} + spd;
    lo_lim  = 11'(X_MIN) + spd;
    posx_d  = posx_q;
    if (state_q == ST_FWD || state_q == ST_BACK) begin
      if (go_plus) posx_d = (sum > 11'(X_MAX)) ? 10'(X_MAX) : sum[9:0];
      else         posx_d = ({1'b0, posx_q} < lo_lim) ? 10'(X_MIN) : (posx_q - spd[9:0]);
    end
  end

  // Fighter registers: everything advances together on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      posx_q   <= 10'(X_INIT);
      health_q <= HP_W'(HP_MAX);
      stun_q   <= '0;
      atk_q    <= ATK_NONE;
      ko_q     <= 1'b0;
    end else if (tick) begin
      state_q  <= state_d;
      posx_q   <= posx_d;
      health_q <= health_d;
      stun_q   <= stun_d;
      atk_q    <= atk_code(state_d);
      ko_q     <= (state_d == ST_KO);
    end
  end

  assign posx       = posx_q;
  assign posy       = POSY;
  assign state      = state_q;
  assign health     = health_q;
  assign atk_active = atk_q;
  assign ko         = ko_q;

endmodule

// File: tb/tb_fighter_fsm.sv
// Scoreboard bench for fighter_fsm: driver queues expected outputs, monitors compare.
// Two instances: left fighter with defaults, right fighter starting at x=427.
module tb_fighter_fsm;

  localparam logic [3:0] S_IDLE = 4'd0, S_FWD = 4'd1, S_BACK = 4'd2;
  localparam logic [3:0] S_BST = 4'd3, S_BACT = 4'd4, S_BREC = 4'd5;
  localparam logic [3:0] S_DST = 4'd6, S_DACT = 4'd7, S_DREC = 4'd8;
  localparam logic [3:0] S_HSTUN = 4'd9, S_BSTUN = 4'd10, S_KO = 4'd11;

  typedef struct {
    logic [3:0] st;
    logic [9:0] px;
    logic [7:0] hp;
    logic [1:0] aa;
    logic       ko;
    int         tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_ctr = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       tick0 = 0, left0 = 0, right0 = 0, atk0 = 0;
  logic [1:0] hf0 = 2'b00;
  logic [9:0] posx0, posy0;
  logic [3:0] state0;
  logic [7:0] health0;
  logic [1:0] aa0;
  logic       ko0;

  logic       tick1 = 0, left1 = 0, right1 = 0, atk1 = 0;
  logic [1:0] hf1 = 2'b00;
  logic [9:0] posx1, posy1;
  logic [3:0] state1;
  logic [7:0] health1;
  logic [1:0] aa1;
  logic       ko1;

  fighter_fsm u_dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick0), .left(left0), .right(right0),
    .attack(atk0), .hit_flag(hf0), .posx(posx0), .posy(posy0), .state(state0),
    .health(health0), .atk_active(aa0), .ko(ko0)
  );

  fighter_fsm #(.SIDE(1), .X_INIT(427)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .left(left1), .right(right1),
    .attack(atk1), .hit_flag(hf1), .posx(posx1), .posy(posy1), .state(state1),
    .health(health1), .atk_active(aa1), .ko(ko1)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int tag, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s tag=%0d got=%0d want=%0d", name, tag, act, want);
    end
  endtask

  task automatic cmp_out(input string who, input exp_t e, input logic [3:0] st,
                         input logic [9:0] px, input logic [7:0] hp, input logic [1:0] aa,
                         input logic k, input logic [9:0] py);
    cmp({who, ".state"},      e.tag, int'(st), int'(e.st));
    cmp({who, ".posx"},       e.tag, int'(px), int'(e.px));
    cmp({who, ".health"},     e.tag, int'(hp), int'(e.hp));
    cmp({who, ".atk_active"}, e.tag, int'(aa), int'(e.aa));
    cmp({who, ".ko"},         e.tag, int'(k),  int'(e.ko));
    cmp({who, ".posy"},       e.tag, int'(py), 170);
  endtask

  // Monitors: one queued expectation per driven cycle, checked after the edge.
  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp_out("d0", e, state0, posx0, health0, aa0, ko0, posy0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp_out("d1", e, state1, posx1, health1, aa1, ko1, posy1);
    end
  end

  task automatic step(input int inst, input bit tk, input bit l, input bit r, input bit a,
                      input logic [1:0] hf, input logic [3:0] st, input int px,
                      input int hp, input logic [1:0] aa, input bit k);
    exp_t e;
    @(negedge clk);
    if (inst == 0) begin
      tick0 = tk; left0 = l; right0 = r; atk0 = a; hf0 = hf;
    end else begin
      tick1 = tk; left1 = l; right1 = r; atk1 = a; hf1 = hf;
    end
    e.st = st; e.px = 10'(px); e.hp = 8'(hp); e.aa = aa; e.ko = k; e.tag = tag_ctr;
    tag_ctr++;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endtask

  task automatic quiet();
    @(negedge clk);
    tick0 = 0; left0 = 0; right0 = 0; atk0 = 0; hf0 = 2'b00;
    tick1 = 0; left1 = 0; right1 = 0; atk1 = 0; hf1 = 2'b00;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    int v;
    do_reset();
    // Reset values, then hit_flag 11 is no hit.
    step(0, 0, 0, 0, 0, 2'b00, S_IDLE, 100, 100, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b11, S_IDLE, 100, 100, 2'b00, 0);

    // Basic attack: attack beats a direction; 5 / 2 / 16 ticks then IDLE.
    step(0, 1, 0, 1, 1, 2'b00, S_BST, 100, 100, 2'b00, 0);
    step(0, 0, 0, 0, 1, 2'b00, S_BST, 100, 100, 2'b00, 0);
    for (int i = 1; i < 5; i++) step(0, 1, 0, 0, 0, 2'b00, S_BST, 100, 100, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b00, S_BACT, 100, 100, 2'b01, 0);
    step(0, 0, 1, 0, 1, 2'b01, S_BACT, 100, 100, 2'b01, 0);
    step(0, 1, 0, 0, 0, 2'b00, S_BACT, 100, 100, 2'b01, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 2'b00, S_BREC, 100, 100, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b00, S_IDLE, 100, 100, 2'b00, 0);

    // Blocked directional hit: BSTUN 12 ticks, no damage, second hit ignored.
    do_reset();
    step(0, 1, 1, 0, 0, 2'b00, S_BACK, 100, 100, 2'b00, 0);
    step(0, 1, 1, 0, 0, 2'b10, S_BSTUN, 98, 100, 2'b00, 0);
    for (int k = 1; k < 12; k++)
      step(0, 1, 0, 0, 0, (k == 3) ? 2'b01 : 2'b00, S_BSTUN, 98, 100, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b00, S_IDLE, 98, 100, 2'b00, 0);

    // Hit on the tick B_ST would expire: hit wins, HSTUN 15 ticks.
    do_reset();
    step(0, 1, 0, 0, 1, 2'b00, S_BST, 100, 100, 2'b00, 0);
    for (int i = 1; i < 5; i++) step(0, 1, 0, 0, 0, 2'b00, S_BST, 100, 100, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b01, S_HSTUN, 100, 90, 2'b00, 0);
    for (int k = 1; k < 15; k++) step(0, 1, 0, 0, 0, 2'b00, S_HSTUN, 100, 90, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b00, S_IDLE, 100, 90, 2'b00, 0);

    // Ten basic hits from IDLE down to KO; KO ignores everything.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 0, 0, 0, 2'b01, S_HSTUN, 100, 100 - 10 * i, 2'b00, 0);
      for (int k = 1; k < 15; k++)
        step(0, 1, 0, 0, 0, (k == 5) ? 2'b10 : 2'b00, S_HSTUN, 100, 100 - 10 * i, 2'b00, 0);
      step(0, 1, 0, 0, 0, 2'b00, S_IDLE, 100, 100 - 10 * i, 2'b00, 0);
    end
    step(0, 1, 0, 0, 0, 2'b01, S_KO, 100, 0, 2'b00, 1);
    step(0, 1, 0, 1, 1, 2'b10, S_KO, 100, 0, 2'b00, 1);
    step(0, 1, 1, 0, 0, 2'b01, S_KO, 100, 0, 2'b00, 1);
    do_reset();
    step(0, 0, 0, 0, 0, 2'b00, S_IDLE, 100, 100, 2'b00, 0);

    // Walk forward, take a hit, then async reset with no clock edge.
    step(0, 1, 0, 1, 0, 2'b00, S_FWD, 100, 100, 2'b00, 0);
    step(0, 1, 0, 1, 0, 2'b00, S_FWD, 103, 100, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b01, S_HSTUN, 106, 90, 2'b00, 0);
    step(0, 1, 0, 0, 0, 2'b00, S_HSTUN, 106, 90, 2'b00, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async.state",  -1, int'(state0),  0);
    cmp("async.posx",   -1, int'(posx0),   100);
    cmp("async.health", -1, int'(health0), 100);
    cmp("async.ko",     -1, int'(ko0),     0);
    quiet();
    rst_n = 1'b1;

    // Right fighter: left held 200 ticks from 427, clamps at 10.
    step(1, 1, 1, 0, 0, 2'b00, S_FWD, 427, 100, 2'b00, 0);
    for (int k = 1; k < 200; k++) begin
      v = 427 - 3 * k;
      if (v < 10) v = 10;
      step(1, 1, 1, 0, 0, 2'b00, S_FWD, v, 100, 2'b00, 0);
    end
    // Directional attack from FWD: 4 / 3 / 15 ticks, then resume FWD.
    step(1, 1, 1, 0, 1, 2'b00, S_DST, 10, 100, 2'b00, 0);
    for (int i = 1; i < 4; i++) step(1, 1, 0, 0, 0, 2'b00, S_DST, 10, 100, 2'b00, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 2'b00, S_DACT, 10, 100, 2'b10, 0);
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0, 2'b00, S_DREC, 10, 100, 2'b00, 0);
    step(1, 1, 1, 0, 0, 2'b00, S_FWD, 10, 100, 2'b00, 0);
    // Right key is away for the right fighter: BACK moves +x.
    step(1, 1, 0, 1, 0, 2'b00, S_BACK, 10, 100, 2'b00, 0);
    step(1, 1, 0, 1, 0, 2'b00, S_BACK, 12, 100, 2'b00, 0);

    quiet();
    quiet();
    cmp("drain.q0", -1, q0.size(), 0);
    cmp("drain.q1", -1, q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
